ual_seq: RTL and testbench

- Parametrised, registered successor to the team's 4-bit combinational ALU.
- Same operand/select/result shape: in0, in1 (W bits), sel (3 bits), out (2W bits).
- Adds a start/busy/done handshake and multi-cycle unsigned multiply and divide (shift-add / restoring), with all results registered.
- Sits between the lab register file and the result display/bus; one operation in flight at a time.

---
 rtl/ual_seq.sv | 90 +++++++++
 tb/tb_ual_seq.sv | 124 ++++++++++++
 2 files changed

// File: rtl/ual_seq.sv
// ual_seq: registered ALU with single-cycle logic/arith ops and multi-cycle shift-add multiply and restoring divide
module ual_seq #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [W-1:0]   in0,
  input  logic [W-1:0]   in1,
  input  logic [2:0]     sel,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] out,
  output logic           div_by_zero
);
  localparam int CW = $clog2(W + 1);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic            div_q;
  logic [2*W-1:0]  p_q, p_d, m_q, m_d, alu;
  logic [W-1:0]    b_q, b_d;
  logic [W:0]      t;
  logic            ge;
  // Single-cycle result for ops 0-5, computed straight from the inputs at the accepting edge
  always_comb begin
    alu = sel == 3'd0 ? {{W{1'b0}}, in0} + {{W{1'b0}}, in1} :
          sel == 3'd1 ? {{W{1'b0}}, in0} - {{W{1'b0}}, in1} :
          sel == 3'd2 ? {{W{1'b0}}, in0 & in1} :
          sel == 3'd3 ? {{W{1'b0}}, in0 | in1} :
          sel == 3'd4 ? {{W{1'b0}}, in0 ^ in1} :
          sel == 3'd5 ? {{W{1'b0}}, in0} << (int'(in1) % (2 * W)) : '0;
  end
  // One iteration step: mul uses p=product, m=shifted multiplicand, b=multiplier;
  // div uses p[W-1:0]=partial remainder, m[W-1:0]=dividend shifting into quotient, b=divisor
  always_comb begin
    t   = {p_q[W-1:0], m_q[W-1]};
    ge  = t >= {1'b0, b_q};
    p_d = div_q ? {{W{1'b0}}, ge ? t[W-1:0] - b_q : t[W-1:0]} : p_q + (b_q[0] ? m_q : '0);
    m_d = div_q ? {{W{1'b0}}, m_q[W-2:0], ge} : m_q << 1;
    b_d = div_q ? b_q : b_q >> 1;
  end
  // Control FSM with registered handshake outputs; out only changes together with done
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      out         <= '0;
      div_by_zero <= 1'b0;
      cnt_q       <= '0;
      div_q       <= 1'b0;
      p_q         <= '0;
      m_q         <= '0;
      b_q         <= '0;
    end else begin
      done <= 1'b0;
      if (state_q != RUN && start) begin
        div_by_zero <= 1'b0;
        cnt_q       <= '0;
        div_q       <= sel[0];
        p_q         <= '0;
        m_q         <= {{W{1'b0}}, in0};
        b_q         <= in1;
        if (sel[2] && sel[1]) begin
          busy    <= 1'b1;
          state_q <= RUN;
        end else begin
          out     <= alu;
          done    <= 1'b1;
          state_q <= FIN;
        end
      end else if (state_q == RUN) begin
        p_q   <= p_d;
        m_q   <= m_d;
        b_q   <= b_d;
        cnt_q <= cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          out         <= div_q ? {p_d[W-1:0], m_d[W-1:0]} : p_d;
          div_by_zero <= div_q && b_q == '0;
          done        <= 1'b1;
          busy        <= 1'b0;
          state_q     <= FIN;
        end
      end else begin
        state_q <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_ual_seq.sv
// tb_ual_seq: directed scoreboard bench for ual_seq at W=4
module tb_ual_seq;
  localparam int W = 4;
  logic           clk = 1'b0;
  logic           reset, start, busy, done, dbz;
  logic [W-1:0]   in0, in1;
  logic [2:0]     sel;
  logic [2*W-1:0] out;
  int             tests = 0, fails = 0;
  logic [2*W:0]   sb[$];

  always #5 clk = ~clk;

  ual_seq #(.W(W)) dut (
    .clk(clk), .reset(reset), .start(start), .in0(in0), .in1(in1), .sel(sel),
    .busy(busy), .done(done), .out(out), .div_by_zero(dbz)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [2*W:0] e;
    @(posedge clk);
    #1;
    if (done) begin
      chk("done_busy_excl", 32'(busy), 0);
      chk("sb_nonempty", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("result", 32'({dbz, out}), 32'(e));
      end
    end
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] s,
                     input logic [2*W-1:0] eo, input logic ed, input bit scramble);
    int n, bc;
    in0 = a; in1 = b; sel = s; start = 1'b1;
    sb.push_back({ed, eo});
    n = 0; bc = 0;
    do begin
      tick();
      n++;
      bc += int'(busy);
      if (scramble && busy) begin
        start = 1'($urandom);
        in0 = W'($urandom);
        in1 = W'($urandom);
        sel = 3'($urandom);
      end else start = 1'b0;
    end while (!done && n < 20);
    chk("latency", n, (s[2] && s[1]) ? W + 1 : 1);
    chk("busy_cycles", bc, (s[2] && s[1]) ? W : 0);
    tick();
    chk("done_pulse", 32'(done), 0);
    chk("out_hold", 32'(out), 32'(eo));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in0 = '0; in1 = '0; sel = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_out", 32'(out), 0);
    chk("rst_dbz", 32'(dbz), 0);
    reset = 1'b0;
    run(4'd2, 4'd3, 3'd0, 8'h05, 1'b0, 1'b0);
    run(4'd2, 4'd3, 3'd1, 8'hFF, 1'b0, 1'b0);
    run(4'hA, 4'h6, 3'd4, 8'h0C, 1'b0, 1'b0);
    run(4'h3, 4'd5, 3'd5, 8'h60, 1'b0, 1'b0);
    run(4'hA, 4'h6, 3'd2, 8'h02, 1'b0, 1'b0);
    run(4'hA, 4'h6, 3'd3, 8'h0E, 1'b0, 1'b0);
    run(4'hF, 4'hF, 3'd0, 8'h1E, 1'b0, 1'b0);
    run(4'd1, 4'd9, 3'd5, 8'h02, 1'b0, 1'b0);
    run(4'hF, 4'hF, 3'd6, 8'hE1, 1'b0, 1'b1);
    run(4'd13, 4'd4, 3'd7, 8'h13, 1'b0, 1'b0);
    run(4'd9, 4'd0, 3'd7, 8'h9F, 1'b1, 1'b0);
    chk("dbz_hold", 32'(dbz), 1);
    run(4'd1, 4'd2, 3'd0, 8'h03, 1'b0, 1'b0);
    run(4'd0, 4'd5, 3'd6, 8'h00, 1'b0, 1'b0);
    run(4'hF, 4'd1, 3'd7, 8'h0F, 1'b0, 1'b0);
    run(4'd7, 4'd7, 3'd7, 8'h01, 1'b0, 1'b0);
    // back-to-back: add accepted in the FIN cycle of a mul
    in0 = 4'd3; in1 = 4'd5; sel = 3'd6; start = 1'b1;
    sb.push_back({1'b0, 8'h0F});
    tick();
    start = 1'b0;
    repeat (W) tick();
    chk("b2b_done1", 32'(done), 1);
    in0 = 4'd1; in1 = 4'd1; sel = 3'd0; start = 1'b1;
    sb.push_back({1'b0, 8'h02});
    tick();
    start = 1'b0;
    chk("b2b_done2", 32'(done), 1);
    chk("b2b_out", 32'(out), 32'h02);
    tick();
    chk("b2b_drop", 32'(done), 0);
    // reset during the second busy cycle aborts with no done
    in0 = 4'hF; in1 = 4'hF; sel = 3'd6; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("mid_busy", 32'(busy), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_out", 32'(out), 0);
    chk("abort_done", 32'(done), 0);
    repeat (6) tick();
    chk("abort_no_done", 32'(done), 0);
    run(4'd2, 4'd3, 3'd0, 8'h05, 1'b0, 1'b0);
    chk("sb_drained", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
